mips_mem_responder: RTL and testbench

Memory-side responder for the multicycle MIPS core. It serves the core's unified instruction/data memory port over a req/ready handshake, with a programmable number of wait states, so the controller's fetch, load and store states can stall on `ready` instead of assuming single-cycle memory. It sits between the datapath's address/writedata mux and the word-addressed RAM. It also flags misaligned and out-of-range accesses.

---
 rtl/mips_decls_p.sv | 15 +
 rtl/mips_ram_1p.sv | 25 ++
 rtl/mips_mem_responder.sv | 136 +++++++++++++
 tb/tb_mips_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_decls_p.sv
// Shared declarations for the multicycle MIPS core: memory responder
// state encoding, counter width and wait-state ceiling.
package mips_decls_p;

  typedef enum logic [1:0] {
    MEMRESP_IDLE = 2'd0,
    MEMRESP_WAIT = 2'd1,
    MEMRESP_RESP = 2'd2,
    MEMRESP_ERR  = 2'd3
  } memresp_state_t;

  localparam int MEMRESP_CNT_W    = 4;
  localparam int MEMRESP_MAX_WAIT = 15;

endpackage

// File: rtl/mips_ram_1p.sv
// Word-addressed single-port RAM: combinational read, synchronous write.
// Contents are not reset.
module mips_ram_1p #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port: one word per edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wd;
    end
  end

  assign rd = mem[idx];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core. Accepts one request
// in IDLE, inserts WAIT_CYCLES wait states, then issues a one-cycle ready
// strobe (err qualifies it for misaligned/out-of-range accesses).
//
// Handshake: req is sampled only while the responder is idle (busy=0);
// we/addr/wdata are latched on that same edge. Exactly one ready pulse
// follows every accepted request, and err is meaningful only while ready
// is high. ready/err trail the RESP/ERR state by one edge because they are
// registered from it, so the ready cycle is also the first idle cycle.
module mips_mem_responder
  import mips_decls_p::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [MEMRESP_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : MEMRESP_CNT_W'(WAIT_CYCLES - 1);

  // Reject impossible configurations at elaboration.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MEMRESP_MAX_WAIT) begin : g_bad_wait
    $error("mips_mem_responder: WAIT_CYCLES out of range 0..15");
  end
  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("mips_mem_responder: DEPTH_WORDS must be a power of 2 in 16..65536");
  end

  memresp_state_t             state;
  logic [MEMRESP_CNT_W-1:0]   cnt;
  logic                       we_q;
  logic [IDX_W-1:0]           idx_q;
  logic [31:0]                wdata_q;

  logic                       addr_ok;
  logic [IDX_W-1:0]           ram_idx;
  logic                       ram_we;
  logic [31:0]                ram_rd;

  // Full-width range check on the word index, so high address bits never alias.
  assign addr_ok = (addr[1:0] == 2'b00) && (addr[31:2] < 30'(DEPTH_WORDS));

  // In IDLE the RAM is addressed by the incoming request so a zero-wait read
  // can capture rdata on the accepting edge; otherwise the latched index.
  assign ram_idx = (state == MEMRESP_IDLE) ? addr[IDX_W+1:2] : idx_q;

  // Store commits on the edge leaving RESP; a reset on that edge drops it.
  assign ram_we  = (state == MEMRESP_RESP) && we_q && reset;

  mips_ram_1p #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .idx (ram_idx),
    .wd  (wdata_q),
    .rd  (ram_rd)
  );

  // Request latches: captured only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == MEMRESP_IDLE && req) begin
      we_q    <= we;
      idx_q   <= addr[IDX_W+1:2];
      wdata_q <= wdata;
    end
  end

  // Control FSM with wait-state counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MEMRESP_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ready <= (state == MEMRESP_RESP) || (state == MEMRESP_ERR);
      err   <= (state == MEMRESP_ERR);
      case (state)
        MEMRESP_IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (!addr_ok) begin
              state <= MEMRESP_ERR;
            end else if (WAIT_CYCLES == 0) begin
              state <= MEMRESP_RESP;
              if (!we) begin
                rdata <= ram_rd;
              end
            end else begin
              cnt   <= CNT_INIT;
              state <= MEMRESP_WAIT;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        MEMRESP_WAIT: begin
          busy <= 1'b1;
          if (cnt == '0) begin
            state <= MEMRESP_RESP;
            if (!we_q) begin
              rdata <= ram_rd;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        MEMRESP_RESP, MEMRESP_ERR: begin
          state <= MEMRESP_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= MEMRESP_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: one instance with the default two wait
// states and one with zero wait states, checked against a word-array model.
module tb_mips_mem_responder;

  localparam int DEPTH = 256;
  localparam int W_A   = 2;
  localparam int W_B   = 0;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_a, we_a, ready_a, err_a, busy_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ready_b, err_b, busy_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] last_rd_a = 32'h0;
  logic [31:0] last_rd_b = 32'h0;
  int          written_a[$];
  logic [31:0] exp_q[$];

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic bit addr_valid(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < DEPTH);
  endfunction

  // Driver: issue one access and wait (bounded) for its ready pulse.
  // lat = number of edges after the accepting edge until ready is seen.
  task automatic acc(input bit sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic e, output int lat, output bit tmo);
    @(negedge clk);
    if (sel) begin req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d; end
    else     begin req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; end
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    tmo = 1'b1; lat = -1; rd = 32'h0; e = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (sel ? ready_b : ready_a) begin
        lat = k; tmo = 1'b0;
        rd  = sel ? rdata_b : rdata_a;
        e   = sel ? err_b : err_a;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Model-checked access on instance A (wait states = W_A).
  task automatic check_a(input string name, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    logic [31:0] rd, exp_rd;
    logic        e;
    int          lat, exp_lat;
    bit          tmo, ok;
    ok      = addr_valid(a);
    exp_lat = ok ? W_A + 1 : 1;
    exp_rd  = (ok && !w) ? mem_a[a / 4] : last_rd_a;
    acc(1'b0, w, a, d, rd, e, lat, tmo);
    n_checks++;
    if (tmo) begin
      n_fail++; $display("FAIL %s timeout: no ready within 40 cycles", name);
      return;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (e !== !ok) begin
      n_fail++; $display("FAIL %s err: got %b expected %b", name, e, !ok);
    end
    n_checks++;
    if (rd !== exp_rd) begin
      n_fail++; $display("FAIL %s rdata: got %h expected %h", name, rd, exp_rd);
    end
    if (ok && w) begin mem_a[a / 4] = d; written_a.push_back(int'(a / 4)); end
    if (ok && !w) last_rd_a = exp_rd;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h40; wdata_a = 32'h5555_AAAA;
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0;  wdata_b = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ready_a, err_a, busy_a} !== 3'b000 || rdata_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_a: ready/err/busy=%b rdata=%h expected 000/0",
                         {ready_a, err_a, busy_a}, rdata_a);
    end
    n_checks++;
    if ({ready_b, err_b, busy_b} !== 3'b000 || rdata_b !== 32'h0) begin
      n_fail++; $display("FAIL reset_b: ready/err/busy=%b rdata=%h expected 000/0",
                         {ready_b, err_b, busy_b}, rdata_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || ready_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_access: busy_a=%b busy_b=%b ready_a=%b expected 0",
                         busy_a, busy_b, ready_a);
    end
  endtask

  task automatic test_write_read;
    check_a("wr_40", 1'b1, 32'h40, 32'hDEADBEEF);
    check_a("rd_40", 1'b0, 32'h40, 32'h0);
  endtask

  task automatic test_misaligned;
    check_a("rd_42_misaligned", 1'b0, 32'h42, 32'h0);
    check_a("rd_40_after_err", 1'b0, 32'h40, 32'h0);
  endtask

  task automatic test_out_of_range;
    check_a("wr_0", 1'b1, 32'h0, 32'h1111_0000);
    check_a("wr_400_oor", 1'b1, 32'h400, 32'hFFFF_FFFF);
    check_a("rd_0_after_oor", 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_wait;
    check_a("wr_10_old", 1'b1, 32'h10, 32'hAAAA_5555);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h10; wdata_a = 32'h1234;
    @(posedge clk);                   // accepted, enters WAIT
    @(negedge clk);
    req_a = 1'b0; reset = 1'b0;       // first WAIT cycle
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_rd_a = 32'h0; last_rd_b = 32'h0;
    n_checks++;
    if (busy_a !== 1'b0 || rdata_a !== 32'h0) begin
      n_fail++; $display("FAIL mid_wait_reset_state: busy=%b rdata=%h expected 0/0",
                         busy_a, rdata_a);
    end
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        if (ready_a === 1'b1) seen++;
        @(negedge clk);
      end
      n_checks++;
      if (seen != 0) begin
        n_fail++; $display("FAIL mid_wait_no_ready: ready pulses=%0d expected 0", seen);
      end
    end
    check_a("rd_10_after_reset", 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int          idx;
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(0, DEPTH - 1);
      check_a("rand_fill", 1'b1, 32'(idx) * 4, $urandom);
    end
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          idx = written_a[$urandom_range(0, written_a.size() - 1)];
          check_a("rand_read", 1'b0, 32'(idx) * 4, 32'h0);
        end
        1: begin
          idx = $urandom_range(0, DEPTH - 1);
          check_a("rand_write", 1'b1, 32'(idx) * 4, $urandom);
        end
        2: begin
          a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
          check_a("rand_misaligned", $urandom_range(0, 1) == 1, a, $urandom);
        end
        default: begin
          a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) * 4;
          check_a("rand_oor", $urandom_range(0, 1) == 1, a, $urandom);
        end
      endcase
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] adr [4];
    logic [31:0] rd, got;
    logic        e;
    int          lat;
    bit          tmo;
    for (int k = 0; k < 4; k++) begin
      adr[k] = 32'(8 * k + 4);
      mem_b[adr[k] / 4] = $urandom;
      acc(1'b1, 1'b1, adr[k], mem_b[adr[k] / 4], rd, e, lat, tmo);
      n_checks++;
      if (tmo || lat !== W_B + 1 || e !== 1'b0) begin
        n_fail++; $display("FAIL b2b_fill%0d: tmo=%b lat=%0d err=%b expected 0/%0d/0",
                           k, tmo, lat, e, W_B + 1);
      end
    end
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b0; addr_b = adr[0];
    exp_q.push_back(mem_b[adr[0] / 4]);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_b !== (i % 2 == 1) || busy_b !== (i % 2 == 0)) begin
        n_fail++; $display("FAIL b2b_cycle%0d: ready=%b busy=%b expected %b/%b",
                           i, ready_b, busy_b, i % 2 == 1, i % 2 == 0);
      end
      if (ready_b === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_checks++;
        if (rdata_b !== got || err_b !== 1'b0) begin
          n_fail++; $display("FAIL b2b_data%0d: rdata=%h err=%b expected %h/0",
                             i, rdata_b, err_b, got);
        end
      end
      addr_b = adr[((i + 1) / 2) % 4];
      if ((i + 1) % 2 == 0 && i < 15) exp_q.push_back(mem_b[addr_b / 4]);
    end
    req_b = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover: %0d responses missing expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
